// File: rtl/cordic_iter_engine_if.sv
// cordic_iter_engine_if: operand/result handshake bundle for cordic_iter_engine.
//   In_valid/In_ready   operand handshake; Mode, X_in, Y_in, Z_in ride with it
//   Out_valid/Out_ready result handshake; X_out, Y_out, Z_out ride with it
// master = operand producer / result consumer, slave = the engine.
interface cordic_iter_engine_if #(parameter int WIDTH = 16);
  logic                    In_valid;
  logic                    In_ready;
  logic                    Mode;
  logic signed [WIDTH-1:0] X_in;
  logic signed [WIDTH-1:0] Y_in;
  logic signed [WIDTH-1:0] Z_in;
  logic                    Out_valid;
  logic                    Out_ready;
  logic signed [WIDTH-1:0] X_out;
  logic signed [WIDTH-1:0] Y_out;
  logic signed [WIDTH-1:0] Z_out;

  modport master (
    output In_valid, Mode, X_in, Y_in, Z_in, Out_ready,
    input  In_ready, Out_valid, X_out, Y_out, Z_out
  );

  modport slave (
    input  In_valid, Mode, X_in, Y_in, Z_in, Out_ready,
    output In_ready, Out_valid, X_out, Y_out, Z_out
  );
endinterface

// File: rtl/cordic_iter_engine.sv
// cordic_iter_engine: iterative CORDIC, one micro-rotation per clock.
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       cordic_iter_engine_if.slave (operand and result handshakes)
//   Sat_flag  sticky X/Y clamp indicator, only when CORDIC_SAT_FLAG_EN is defined
// Mode 0 = rotation (drive Z to 0), Mode 1 = vectoring (drive Y to 0).
// Angles: 2^(WIDTH-1) == pi. No gain compensation (K ~ 1.6468).
// Timing: accept edge, ITER step cycles, one transfer cycle, then Out_valid.
module cordic_iter_engine #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic clk,
  input  logic rst,
  cordic_iter_engine_if.slave bus
`ifdef CORDIC_SAT_FLAG_EN
  ,
  output logic Sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  r_state;
  logic [4:0]              r_i;
  logic                    r_mode;
  logic signed [WIDTH-1:0] r_x, r_y, r_z;
  logic signed [WIDTH-1:0] r_xo, r_yo, r_zo;
  logic                    r_ov;
  logic                    r_ir;

  // atan(2^-i) with 2^31 == pi
  function automatic logic [31:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:  atan_lut = 32'd536870912;
      4'd1:  atan_lut = 32'd316933406;
      4'd2:  atan_lut = 32'd167458907;
      4'd3:  atan_lut = 32'd85004756;
      4'd4:  atan_lut = 32'd42667331;
      4'd5:  atan_lut = 32'd21354465;
      4'd6:  atan_lut = 32'd10679838;
      4'd7:  atan_lut = 32'd5340245;
      4'd8:  atan_lut = 32'd2670163;
      4'd9:  atan_lut = 32'd1335087;
      4'd10: atan_lut = 32'd667544;
      4'd11: atan_lut = 32'd333772;
      4'd12: atan_lut = 32'd166886;
      4'd13: atan_lut = 32'd83443;
      4'd14: atan_lut = 32'd41722;
      default: atan_lut = 32'd20861;
    endcase
  endfunction

  // table entry rescaled to WIDTH bits by truncation
  function automatic logic signed [WIDTH-1:0] atan_w(input logic [3:0] idx);
    logic [31:0] t;
    t = atan_lut(idx) >> (32 - WIDTH);
    return t[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1])
      return v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      return v[WIDTH-1:0];
  endfunction

  // direction: 1 means d = +1
  logic                    w_dpos;
  logic signed [WIDTH-1:0] w_xs, w_ys, w_at, w_zn;
  logic signed [WIDTH:0]   w_xe, w_ye, w_xse, w_yse, w_xw, w_yw;

  assign w_dpos = r_mode ? r_y[WIDTH-1] : ~r_z[WIDTH-1];
  assign w_xs   = r_x >>> r_i;
  assign w_ys   = r_y >>> r_i;
  assign w_xe   = {r_x[WIDTH-1], r_x};
  assign w_ye   = {r_y[WIDTH-1], r_y};
  assign w_xse  = {w_xs[WIDTH-1], w_xs};
  assign w_yse  = {w_ys[WIDTH-1], w_ys};
  assign w_xw   = w_dpos ? (w_xe - w_yse) : (w_xe + w_yse);
  assign w_yw   = w_dpos ? (w_ye + w_xse) : (w_ye - w_xse);
  assign w_at   = atan_w(r_i[3:0]);
  // Z wraps naturally at WIDTH bits
  assign w_zn   = w_dpos ? (r_z - w_at) : (r_z + w_at);

`ifdef CORDIC_SAT_FLAG_EN
  logic r_sat;
  logic w_ovf;
  assign w_ovf    = (w_xw[WIDTH] ^ w_xw[WIDTH-1]) | (w_yw[WIDTH] ^ w_yw[WIDTH-1]);
  assign Sat_flag = r_sat;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_mode  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_xo    <= '0;
      r_yo    <= '0;
      r_zo    <= '0;
      r_ov    <= 1'b0;
      r_ir    <= 1'b1;
`ifdef CORDIC_SAT_FLAG_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.In_valid && r_ir) begin
            r_x     <= bus.X_in;
            r_y     <= bus.Y_in;
            r_z     <= bus.Z_in;
            r_mode  <= bus.Mode;
            r_i     <= '0;
            r_ir    <= 1'b0;
            r_state <= RUN;
`ifdef CORDIC_SAT_FLAG_EN
            r_sat   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (r_i == 5'(ITER)) begin
            // transfer cycle: publish the final vector
            r_xo    <= r_x;
            r_yo    <= r_y;
            r_zo    <= r_z;
            r_ov    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_x <= sat(w_xw);
            r_y <= sat(w_yw);
            r_z <= w_zn;
            r_i <= r_i + 5'd1;
`ifdef CORDIC_SAT_FLAG_EN
            r_sat <= r_sat | w_ovf;
`endif
          end
        end
        DONE: begin
          if (bus.Out_ready) begin
            r_ov    <= 1'b0;
            r_ir    <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.In_ready  = r_ir;
  assign bus.Out_valid = r_ov;
  assign bus.X_out     = r_xo;
  assign bus.Y_out     = r_yo;
  assign bus.Z_out     = r_zo;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb_cordic_iter_engine: randomized + directed bench for cordic_iter_engine
// (WIDTH=16, ITER=16) against a plain-integer reference model.
module tb_cordic_iter_engine;
  localparam int W    = 16;
  localparam int ITER = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_iter_engine_if #(.WIDTH(W)) bus();

`ifdef CORDIC_SAT_FLAG_EN
  logic sat_flag;
`endif

  cordic_iter_engine #(.WIDTH(W), .ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef CORDIC_SAT_FLAG_EN
    ,
    .Sat_flag (sat_flag)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int at[ITER];
  int rx, ry, rz;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // reference: ITER CORDIC steps in plain integers
  task automatic model(input bit m, input int x0, input int y0, input int z0,
                       output int xo, output int yo, output int zo, output bit so);
    int x, y, z, xs, ys, d, nx, ny;
    logic signed [15:0] zt;
    x = x0; y = y0; z = z0; so = 1'b0;
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (m) d = (y < 0) ? 1 : -1;
      else   d = (z >= 0) ? 1 : -1;
      nx = x - d * ys;
      ny = y + d * xs;
      if (nx != clamp(nx) || ny != clamp(ny)) so = 1'b1;
      x  = clamp(nx);
      y  = clamp(ny);
      zt = 16'(z - d * at[i]);
      z  = int'(zt);
    end
    xo = x; yo = y; zo = z;
  endtask

  task automatic run_op(input bit m, input int x, input int y, input int z, input int hold);
    int n, lat, ex, ey, ez;
    bit es;
    n = 0;
    while (!bus.In_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", int'(bus.In_ready), 1);
    if (!bus.In_ready) return;
    bus.Mode     = m;
    bus.X_in     = 16'(x);
    bus.Y_in     = 16'(y);
    bus.Z_in     = 16'(z);
    bus.In_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_busy", int'(bus.In_ready), 0);
    // keep In_valid high with junk for a few cycles: must be ignored
    bus.X_in = 16'($urandom);
    bus.Y_in = 16'($urandom);
    bus.Z_in = 16'($urandom);
    bus.Mode = ~m;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat >= 3) bus.In_valid = 1'b0;
    end while (!bus.Out_valid && lat < 60);
    bus.In_valid = 1'b0;
    chk("latency", lat, ITER + 1);
    model(m, x, y, z, ex, ey, ez, es);
    rx = int'(bus.X_out); ry = int'(bus.Y_out); rz = int'(bus.Z_out);
    chk("x_out", rx, ex);
    chk("y_out", ry, ey);
    chk("z_out", rz, ez);
`ifdef CORDIC_SAT_FLAG_EN
    chk("sat_flag", int'(sat_flag), int'(es));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", int'(bus.Out_valid), 1);
      chk("hold_x", int'(bus.X_out), ex);
      chk("hold_y", int'(bus.Y_out), ey);
      chk("hold_z", int'(bus.Z_out), ez);
      chk("hold_ir", int'(bus.In_ready), 0);
    end
    bus.Out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.Out_ready = 1'b0;
    chk("post_hs_valid", int'(bus.Out_valid), 0);
    chk("post_hs_ir", int'(bus.In_ready), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ir"}, int'(bus.In_ready), 1);
    chk({tag, "_ov"}, int'(bus.Out_valid), 0);
    chk({tag, "_x"}, int'(bus.X_out), 0);
    chk({tag, "_y"}, int'(bus.Y_out), 0);
    chk({tag, "_z"}, int'(bus.Z_out), 0);
`ifdef CORDIC_SAT_FLAG_EN
    chk({tag, "_sat"}, int'(sat_flag), 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < ITER; i++)
      at[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 2147483648.0 / 3.14159265358979 + 0.5) >>> 16;
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b0;
    bus.Mode      = 1'b0;
    bus.X_in      = '0;
    bus.Y_in      = '0;
    bus.Z_in      = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_op(1'b0, 19898, 0, 0, 0);
    chk("r28_x", int'(rx >= 32760 && rx <= 32767), 1);
    chk("r28_y", int'(iabs(ry) <= 4), 1);
    chk("r28_z", int'(iabs(rz) <= 4), 1);

    run_op(1'b0, 19898, 0, 16384, 1);
    chk("r29_x", int'(iabs(rx) <= 8), 1);
    chk("r29_y", int'(ry >= 32760 && ry <= 32767), 1);

    run_op(1'b1, 10000, 10000, 0, 0);
    chk("r30_x", int'(iabs(rx - 23290) <= 8), 1);
    chk("r30_y", int'(iabs(ry) <= 4), 1);
    chk("r30_z", int'(iabs(rz - 8192) <= 4), 1);

    run_op(1'b0, 30000, 30000, 0, 5);
`ifdef CORDIC_SAT_FLAG_EN
    chk("r31_sat", int'(sat_flag), 1);
`endif

    // reset in the middle of RUN
    bus.Mode = 1'b0; bus.X_in = 16'(12345); bus.Y_in = 16'(-2222); bus.Z_in = 16'(7000);
    bus.In_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.In_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midrst");
    run_op(1'b1, -15000, 4000, 0, 2);

    // randomized operations
    for (int k = 0; k < 40; k++) begin
      int x, y, z;
      bit m;
      m = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        x = int'($signed(16'($urandom)));
        y = int'($signed(16'($urandom)));
      end else begin
        x = int'($urandom_range(0, 40000)) - 20000;
        y = int'($urandom_range(0, 40000)) - 20000;
      end
      z = m ? 0 : int'($signed(16'($urandom)));
      run_op(m, x, y, z, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cordic_iter_engine.md
CORDIC_ITER_ENGINE -- requirements
Module: cordic_iter_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data and angle width in bits; legal range 8..32.
REQ-002 SHALL have parameter ITER, default 16, giving the number of micro-rotations; legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port In_valid, input, 1 bit: operands valid.
REQ-006 SHALL have port In_ready, output, 1 bit: engine able to accept operands.
REQ-007 SHALL have port Mode, input, 1 bit: 0 selects rotation, 1 selects vectoring; captured on accept.
REQ-008 SHALL have ports X_in and Y_in, inputs, WIDTH bits each, signed: input vector.
REQ-009 SHALL have port Z_in, input, WIDTH bits, signed: angle, where 2^(WIDTH-1) represents pi.
REQ-010 SHALL have ports X_out, Y_out and Z_out, outputs, WIDTH bits each, signed: results.
REQ-011 SHALL have port Out_valid, output, 1 bit: results valid.
REQ-012 SHALL have port Out_ready, input, 1 bit: consumer accepts results.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL assert In_ready only in IDLE; accept occurs when In_valid and In_ready are both 1, registering X_in, Y_in, Z_in and Mode, clearing iteration counter i, and moving to RUN.
REQ-015 SHALL perform one micro-rotation per cycle in RUN for i = 0..ITER-1, then move to DONE.
REQ-016 SHALL set direction d = +1 in rotation mode when Z >= 0, else -1; in vectoring mode d = +1 when Y < 0, else -1.
REQ-017 SHALL per step compute X' = sat(X - d*(Y>>>i)), Y' = sat(Y + d*(X>>>i)) and Z' = Z - d*atan_i, using arithmetic shifts on the pre-step values.
REQ-018 SHALL evaluate X' and Y' at WIDTH+1 bits and clamp them to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; Z SHALL wrap modulo 2^WIDTH without saturation.
REQ-019 SHALL hold atan_i as a 16-entry constant table of atan(2^-i) scaled so that 2^31 represents pi, arithmetic-right-shifted by 32-WIDTH (truncation).
REQ-020 SHALL not compensate for the CORDIC gain (approx. 1.6468).
REQ-021 SHALL assert Out_valid in DONE exactly ITER+1 cycles after the accept edge, with X_out/Y_out/Z_out stable for as long as Out_valid is 1.
REQ-022 SHALL, in DONE, hold the results while Out_ready = 0, and on Out_valid and Out_ready both 1 move to IDLE, with In_ready = 1 on the following cycle.
REQ-023 SHALL ignore In_valid outside IDLE; operands SHALL not be queued.

Reset
REQ-024 SHALL, when rst = 1 at a clock edge in any state, including mid-RUN, force IDLE, In_ready = 1, Out_valid = 0, X_out = Y_out = Z_out = 0, i = 0 and Sat_flag = 0.
REQ-025 SHALL discard any in-flight operation on reset, with no Out_valid pulse for it.

Configuration
REQ-026 SHALL, when macro CORDIC_SAT_FLAG_EN is defined, add output Sat_flag (1 bit) that clears on accept, sets sticky when any X or Y clamp occurs in the operation, and is valid with Out_valid.
REQ-027 SHALL, when CORDIC_SAT_FLAG_EN is not defined, omit port Sat_flag and its logic, leaving datapath and timing identical.

Verification (WIDTH=16, ITER=16)
REQ-028 SHALL cover rotation X=19898, Y=0, Z=0 -> X_out in 32760..32767, |Y_out| <= 4, |Z_out| <= 4, Out_valid 17 cycles after accept.
REQ-029 SHALL cover rotation X=19898, Y=0, Z=16384 -> |X_out| <= 8, Y_out in 32760..32767.
REQ-030 SHALL cover vectoring X=10000, Y=10000, Z=0 -> X_out 23290 +/-8, |Y_out| <= 4, Z_out 8192 +/-4.
REQ-031 SHALL cover rotation X=30000, Y=30000, Z=0 -> X and Y never exceed [-32768, 32767], and Sat_flag = 1 when CORDIC_SAT_FLAG_EN is defined.
REQ-032 SHALL cover Out_ready held 0 for 5 cycles -> Out_valid and results held; In_ready stays 0 until 1 cycle after the handshake.
REQ-033 SHALL cover rst pulsed at RUN step 7 -> IDLE, outputs 0, no Out_valid; a new operation is accepted on the next cycle.
